miriscv_data_mem: RTL and testbench

MIRISCV_DATA_MEM -- requirements
Module: miriscv_data_mem

---
 rtl/miriscv_data_mem.sv | 134 +++++++++++++
 tb/tb_miriscv_data_mem.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/miriscv_data_mem.sv
// rtl/miriscv_data_mem.sv - multi-cycle data memory with byte-enabled stores and request kill
package miriscv_pkg;
  parameter int XLEN = 32;
endpackage

module miriscv_data_mem
  import miriscv_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [XLEN/8-1:0] data_be_i,
  input  logic [XLEN-1:0]   data_addr_i,
  input  logic [XLEN-1:0]   data_wdata_i,
  output logic              data_rvalid_o,
  output logic [XLEN-1:0]   data_rdata_o
);

  localparam int         IDX_W    = $clog2(MEM_WORDS);
  localparam int         NBYTES   = XLEN / 8;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  localparam bit         SINGLE   = (LATENCY == 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q;
  logic                we_q;
  logic [NBYTES-1:0]   be_q;
  logic [XLEN-1:0]     addr_q;
  logic [XLEN-1:0]     wdata_q;
  logic                rd_hit_q;
  logic [XLEN-1:0]     rd_word_q;
  logic [XLEN-1:0]     mem [MEM_WORDS];

  logic                accept;
  logic                enter_resp;
  logic                acc_we;
  logic [NBYTES-1:0]   acc_be;
  logic [XLEN-1:0]     acc_addr;
  logic [XLEN-1:0]     acc_wdata;
  logic                acc_in_range;
  logic [IDX_W-1:0]    acc_idx;
  logic                mem_we;
  logic                mem_re;
  logic                unused_addr_lsb;

  assign accept     = (state_q == IDLE) && data_req_i;
  assign enter_resp = (state_d == RESP) && (state_q != RESP);

  // With LATENCY=1 the RESP edge is the accept edge, so the live inputs are used directly.
  assign acc_we    = (state_q == IDLE) ? data_we_i    : we_q;
  assign acc_be    = (state_q == IDLE) ? data_be_i    : be_q;
  assign acc_addr  = (state_q == IDLE) ? data_addr_i  : addr_q;
  assign acc_wdata = (state_q == IDLE) ? data_wdata_i : wdata_q;

  assign acc_in_range    = (acc_addr[XLEN-1:IDX_W+2] == '0);
  assign acc_idx         = acc_addr[IDX_W+1:2];
  assign unused_addr_lsb = ^acc_addr[1:0];

  // arstn_i gates the write so a held request cannot commit while the FSM is held in reset.
  assign mem_we = enter_resp && arstn_i && acc_we && acc_in_range;
  assign mem_re = enter_resp && !acc_we && acc_in_range;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_hit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_hit_q <= mem_re;
      if (accept) begin
        we_q    <= data_we_i;
        be_q    <= data_be_i;
        addr_q  <= data_addr_i;
        wdata_q <= data_wdata_i;
        cnt_q   <= CNT_INIT;
      end else if ((state_q == BUSY) && data_req_i && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (data_req_i) begin
          state_d = SINGLE ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (!data_req_i) begin
          state_d = IDLE;
        end else if (cnt_q <= 4'd1) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (acc_be[k]) begin
          mem[acc_idx][8*k +: 8] <= acc_wdata[8*k +: 8];
        end
      end
    end
    if (mem_re) begin
      rd_word_q <= mem[acc_idx];
    end
  end

  always_comb begin
    data_rvalid_o = (state_q == RESP);
    data_rdata_o  = '0;
    if ((state_q == RESP) && rd_hit_q) begin
      data_rdata_o = rd_word_q;
    end
  end

endmodule

// File: tb/tb_miriscv_data_mem.sv
// tb/tb_miriscv_data_mem.sv - randomized self-checking bench for miriscv_data_mem at LATENCY 2, 1 and 15
module tb_miriscv_data_mem;

  localparam int ND = 3;

  logic        clk   = 1'b0;
  logic        arstn = 1'b0;
  logic        req    [ND];
  logic        we     [ND];
  logic [3:0]  be     [ND];
  logic [31:0] addr   [ND];
  logic [31:0] wdata  [ND];
  logic        rvalid [ND];
  logic [31:0] rdata  [ND];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] ref_mem   [ND][1024];
  logic [3:0]  ref_known [ND][1024];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  miriscv_data_mem #(.MEM_WORDS(1024), .LATENCY(2)) u_dut0 (
    .clk_i(clk), .arstn_i(arstn), .data_req_i(req[0]), .data_we_i(we[0]), .data_be_i(be[0]),
    .data_addr_i(addr[0]), .data_wdata_i(wdata[0]), .data_rvalid_o(rvalid[0]), .data_rdata_o(rdata[0]));
  miriscv_data_mem #(.MEM_WORDS(16), .LATENCY(1)) u_dut1 (
    .clk_i(clk), .arstn_i(arstn), .data_req_i(req[1]), .data_we_i(we[1]), .data_be_i(be[1]),
    .data_addr_i(addr[1]), .data_wdata_i(wdata[1]), .data_rvalid_o(rvalid[1]), .data_rdata_o(rdata[1]));
  miriscv_data_mem #(.MEM_WORDS(16), .LATENCY(15)) u_dut2 (
    .clk_i(clk), .arstn_i(arstn), .data_req_i(req[2]), .data_we_i(we[2]), .data_be_i(be[2]),
    .data_addr_i(addr[2]), .data_wdata_i(wdata[2]), .data_rvalid_o(rvalid[2]), .data_rdata_o(rdata[2]));

  function automatic int lat_of(input int d);
    case (d)
      0:       return 2;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  function automatic int words_of(input int d);
    return (d == 0) ? 1024 : 16;
  endfunction

  // Reference model: word array plus per-byte "written" flags; unknown bytes are masked out of compares.
  function automatic void model(input int d, input logic w, input logic [3:0] b, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] exp, output logic [31:0] mask);
    bit in_range = (a < 32'(words_of(d) * 4));
    int idx      = int'(a >> 2);
    exp  = '0;
    mask = '1;
    if (in_range) begin
      for (int k = 0; k < 4; k++) begin
        if (w) begin
          if (b[k]) begin
            ref_mem[d][idx][8*k +: 8] = wd[8*k +: 8];
            ref_known[d][idx][k] = 1'b1;
          end
        end else begin
          exp[8*k +: 8]  = ref_mem[d][idx][8*k +: 8];
          mask[8*k +: 8] = ref_known[d][idx][k] ? 8'hFF : 8'h00;
        end
      end
    end
  endfunction

  // Drives one access, scrambling the request fields while waiting, and returns what came back.
  task automatic access(input int d, input logic w, input logic [3:0] b, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output int lat,
                        output int idle_bad, output int rcyc);
    lat = -1; rd = '0; idle_bad = 0; rcyc = -1;
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; be[d] = b; addr[d] = a; wdata[d] = wd;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      we[d] = 1'($urandom); be[d] = 4'($urandom); addr[d] = $urandom; wdata[d] = $urandom;
      if (rvalid[d]) begin
        lat = n; rd = rdata[d]; rcyc = cyc;
        break;
      end
      if (rdata[d] !== 32'h0) idle_bad++;
    end
    req[d] = 1'b0;
  endtask

  task automatic do_op(input int d, input logic w, input logic [3:0] b, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic [31:0] exp,
                       output logic [31:0] mask, output int lat, output int idle_bad, output int rcyc);
    access(d, w, b, a, wd, rd, lat, idle_bad, rcyc);
    model(d, w, b, a, wd, exp, mask);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      n_checks++;
      if (rvalid[d] !== 1'b0 || rdata[d] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_outputs dut%0d: rvalid=%b rdata=%h, required rvalid=0 rdata=0", d, rvalid[d], rdata[d]);
      end
    end
    @(posedge clk);
    #1 arstn = 1'b1;
  endtask

  task automatic test_store_load;
    logic [31:0] rd, exp, mask; int lat, ib, rc0, rc1;
    do_op(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, rd, exp, mask, lat, ib, rc0);
    n_checks++;
    if (lat !== 2 || rd !== 32'h0 || ib != 0) begin
      n_fail++;
      $display("FAIL first_store: lat=%0d rdata=%h idle_bad=%0d, required lat=2 rdata=0 idle_bad=0", lat, rd, ib);
    end
    do_op(0, 1'b0, 4'h0, 32'h10, 32'h0, rd, exp, mask, lat, ib, rc1);
    n_checks++;
    if (lat !== 2 || rd !== 32'hDEADBEEF || (rc1 - rc0) != 3) begin
      n_fail++;
      $display("FAIL store_then_load: lat=%0d rdata=%h gap=%0d, required lat=2 rdata=deadbeef gap=3", lat, rd, rc1 - rc0);
    end
  endtask

  task automatic test_byte_store;
    logic [31:0] rd, exp, mask; int lat, ib, rc;
    do_op(0, 1'b1, 4'b0100, 32'h12, 32'h00AA0000, rd, exp, mask, lat, ib, rc);
    do_op(0, 1'b0, 4'hF, 32'h10, 32'h0, rd, exp, mask, lat, ib, rc);
    n_checks++;
    if (rd !== 32'hDEAABEEF || (rd & mask) !== (exp & mask)) begin
      n_fail++;
      $display("FAIL byte_store: rdata=%h, required deaabeef (model %h)", rd, exp);
    end
  endtask

  task automatic test_kill;
    logic [31:0] rd, exp, mask; int lat, ib, rc, seen;
    for (int i = 0; i < 2; i++) begin
      int d = (i == 0) ? 0 : 2;
      int k = (i == 0) ? 1 : int'($urandom_range(1, 13));
      do_op(d, 1'b1, 4'hF, 32'h20, 32'h13572468, rd, exp, mask, lat, ib, rc);
      @(negedge clk);
      req[d] = 1'b1; we[d] = 1'b1; be[d] = 4'hF; addr[d] = 32'h20; wdata[d] = 32'h55555555;
      seen = 0;
      for (int n = 1; n <= lat_of(d) + 2; n++) begin
        @(negedge clk);
        if (n == k) req[d] = 1'b0;
        if (rvalid[d]) seen++;
      end
      n_checks++;
      if (seen != 0) begin
        n_fail++;
        $display("FAIL kill_no_rvalid dut%0d: rvalid pulses=%0d, required 0", d, seen);
      end
      do_op(d, 1'b0, 4'h0, 32'h20, 32'h0, rd, exp, mask, lat, ib, rc);
      n_checks++;
      if (lat !== lat_of(d) || (rd & mask) !== (exp & mask)) begin
        n_fail++;
        $display("FAIL kill_no_write dut%0d: lat=%0d rdata=%h, required lat=%0d rdata=%h", d, lat, rd, lat_of(d), exp);
      end
    end
  endtask

  task automatic test_out_of_range;
    logic [31:0] rd, exp, mask; int lat, ib, rc;
    do_op(0, 1'b1, 4'hF, 32'h0, 32'hA5A5A5A5, rd, exp, mask, lat, ib, rc);
    do_op(0, 1'b1, 4'hF, 32'h1000, 32'hFFFFFFFF, rd, exp, mask, lat, ib, rc);
    n_checks++;
    if (lat !== 2 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL oor_store_timing: lat=%0d rdata=%h, required lat=2 rdata=0", lat, rd);
    end
    do_op(0, 1'b0, 4'hF, 32'h1000, 32'h0, rd, exp, mask, lat, ib, rc);
    n_checks++;
    if (lat !== 2 || rd !== 32'h0 || ib != 0) begin
      n_fail++;
      $display("FAIL oor_load: lat=%0d rdata=%h idle_bad=%0d, required lat=2 rdata=0 idle_bad=0", lat, rd, ib);
    end
    do_op(0, 1'b0, 4'hF, 32'h0, 32'h0, rd, exp, mask, lat, ib, rc);
    n_checks++;
    if (rd !== 32'hA5A5A5A5 || (rd & mask) !== (exp & mask)) begin
      n_fail++;
      $display("FAIL oor_store_dropped: word0=%h, required a5a5a5a5", rd);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd, exp, mask; int lat, ib, rc, seen;
    do_op(0, 1'b1, 4'hF, 32'h40, 32'h0BADCAFE, rd, exp, mask, lat, ib, rc);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF; addr[0] = 32'h40; wdata[0] = 32'hCAFEF00D;
    @(negedge clk);
    arstn = 1'b0; req[0] = 1'b0;
    #1;
    n_checks++;
    if (rvalid[0] !== 1'b0 || rdata[0] !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: rvalid=%b rdata=%h, required 0/0", rvalid[0], rdata[0]);
    end
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (rvalid[0]) seen++;
    end
    @(posedge clk);
    #1 arstn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (rvalid[0]) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL reset_mid_rvalid: rvalid pulses=%0d, required 0", seen);
    end
    do_op(0, 1'b0, 4'h0, 32'h40, 32'h0, rd, exp, mask, lat, ib, rc);
    n_checks++;
    if (lat !== 2 || rd !== 32'h0BADCAFE) begin
      n_fail++;
      $display("FAIL reset_mid_no_write: lat=%0d rdata=%h, required lat=2 rdata=0badcafe", lat, rd);
    end
  endtask

  task automatic test_latency;
    logic [31:0] rd, exp, mask, v; int lat, ib, rc, w;
    for (int d = 1; d < ND; d++) begin
      w = words_of(d);
      v = $urandom;
      do_op(d, 1'b1, 4'hF, 32'(w * 4 - 4), v, rd, exp, mask, lat, ib, rc);
      n_checks++;
      if (lat !== lat_of(d) || rd !== 32'h0 || ib != 0) begin
        n_fail++;
        $display("FAIL latency_store dut%0d: lat=%0d rdata=%h, required lat=%0d rdata=0", d, lat, rd, lat_of(d));
      end
      do_op(d, 1'b1, 4'hF, 32'(w * 4), ~v, rd, exp, mask, lat, ib, rc);
      do_op(d, 1'b0, 4'h0, 32'(w * 4), 32'h0, rd, exp, mask, lat, ib, rc);
      n_checks++;
      if (lat !== lat_of(d) || rd !== 32'h0) begin
        n_fail++;
        $display("FAIL latency_oor_load dut%0d: lat=%0d rdata=%h, required lat=%0d rdata=0", d, lat, rd, lat_of(d));
      end
      do_op(d, 1'b0, 4'h0, 32'(w * 4 - 1), 32'h0, rd, exp, mask, lat, ib, rc);
      n_checks++;
      if (lat !== lat_of(d) || rd !== v || (rd & mask) !== (exp & mask)) begin
        n_fail++;
        $display("FAIL latency_last_word dut%0d: lat=%0d rdata=%h, required lat=%0d rdata=%h", d, lat, rd, lat_of(d), v);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd, exp, mask; int lat, ib, rc, prev, bad;
    for (int d = 0; d < ND; d++) begin
      bad = 0; prev = -1;
      for (int i = 0; i < 4; i++) begin
        do_op(d, 1'b0, 4'h0, 32'h20, 32'h0, rd, exp, mask, lat, ib, rc);
        if ((rd & mask) !== (exp & mask) || lat !== lat_of(d)) bad++;
        if (prev >= 0 && (rc - prev) != lat_of(d) + 1) bad++;
        prev = rc;
      end
      n_checks++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL back_to_back dut%0d: %0d bad responses, required 0 (period %0d)", d, bad, lat_of(d) + 1);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] rd, exp, mask, a; logic w; logic [3:0] b; int lat, ib, rc, wds, sel;
    for (int d = 0; d < ND; d++) begin
      wds = words_of(d);
      for (int i = 0; i <= 16; i++) begin
        a = (i == 16) ? 32'(wds * 4 - 4) : 32'(i * 4);
        do_op(d, 1'b1, 4'hF, a, $urandom, rd, exp, mask, lat, ib, rc);
      end
      for (int i = 0; i < 30; i++) begin
        sel = int'($urandom_range(0, 9));
        if (sel < 7)       a = 32'($urandom_range(0, 15) * 4);
        else if (sel == 7) a = 32'(wds * 4 - 4);
        else               a = 32'(wds * 4) + 32'($urandom_range(0, 255));
        a[1:0] = 2'($urandom);
        w = 1'($urandom);
        b = 4'($urandom);
        do_op(d, w, b, a, $urandom, rd, exp, mask, lat, ib, rc);
        n_checks++;
        if (lat !== lat_of(d) || (rd & mask) !== (exp & mask) || ib != 0) begin
          n_fail++;
          $display("FAIL random dut%0d op%0d we=%b addr=%h: lat=%0d rdata=%h idle_bad=%0d, required lat=%0d rdata=%h",
                   d, i, w, a, lat, rd, ib, lat_of(d), exp & mask);
        end
      end
    end
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; be[d] = '0; addr[d] = '0; wdata[d] = '0;
      for (int i = 0; i < 1024; i++) ref_known[d][i] = 4'h0;
    end
    test_reset;
    test_store_load;
    test_byte_store;
    test_kill;
    test_out_of_range;
    test_reset_mid;
    test_latency;
    test_back_to_back;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion before it");
    $fatal(1);
  end

endmodule
